// File: rtl/imm_pkg.sv
// Shared definitions for the LEGv8 immediate generator: immediate classes,
// opcode match constants, field bit positions and the class decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_B26  = 3'd1,
    KIND_CB19 = 3'd2,
    KIND_D9   = 3'd3,
    KIND_I12  = 3'd4,
    KIND_MW16 = 3'd5
  } imm_kind_t;

  // Opcode match values, compared against the top bits of the word
  localparam logic [5:0]  OP_B     = 6'b000101;      // [31:26]
  localparam logic [5:0]  OP_BL    = 6'b100101;      // [31:26]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;    // [31:24]
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;    // [31:24]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;    // [31:24]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010; // [31:21]
  localparam logic [10:0] OP_STUR  = 11'b11111000000; // [31:21]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;  // [31:22]
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;  // [31:22]
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;    // [31:23]

  // Immediate field positions (lsb, width)
  localparam int B26_LSB   = 0;
  localparam int B26_W     = 26;
  localparam int CB19_LSB  = 5;
  localparam int CB19_W    = 19;
  localparam int D9_LSB    = 12;
  localparam int D9_W      = 9;
  localparam int I12_LSB   = 10;
  localparam int I12_W     = 12;
  localparam int MW16_LSB  = 5;
  localparam int MW16_W    = 16;
  localparam int MW_HW_LSB = 21;

  // Classify an instruction word; unknown encodings map to NONE
  function automatic imm_kind_t decode_kind(input logic [31:0] instr);
    imm_kind_t k;
    k = KIND_NONE;
    if (instr[31:26] == OP_B || instr[31:26] == OP_BL)
      k = KIND_B26;
    else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ || instr[31:24] == OP_BCOND)
      k = KIND_CB19;
    else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR)
      k = KIND_D9;
    else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI)
      k = KIND_I12;
    else if (instr[31:23] == OP_MOVZ)
      k = KIND_MW16;
    return k;
  endfunction

endpackage

// File: rtl/imm_gen_ctrl_if.sv
// Handshake bus of the immediate generator: instruction in, decoded entry out.
interface imm_gen_ctrl_if #(parameter int OUT_W = 64);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm;
  imm_kind_t        imm_kind;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, imm, imm_kind
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, imm, imm_kind
  );

endinterface

// File: rtl/imm_field_ext.sv
// Field select and sign/zero extension of the LEGv8 immediate to OUT_W bits.
// Optional macro BRANCH_SHL2_EN: branch offsets (B26, CB19) are shifted left
// by 2 to become byte offsets; otherwise they stay word offsets.
module imm_field_ext
  import imm_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic [31:0]      instr,
  output logic [OUT_W-1:0] imm,
  output imm_kind_t        kind
);

  logic [OUT_W-1:0] b26_ext;
  logic [OUT_W-1:0] cb19_ext;
  logic [OUT_W-1:0] d9_ext;
  logic [OUT_W-1:0] i12_ext;
  logic [OUT_W-1:0] mw16_ext;
  logic [OUT_W-1:0] b26_off;
  logic [OUT_W-1:0] cb19_off;
  logic [5:0]       mw_shift;
  logic             unused_bits;

  // Rd/Rt bits never carry immediate data
  assign unused_bits = ^instr[4:0];

  assign kind = decode_kind(instr);

  assign b26_ext  = {{(OUT_W-B26_W){instr[B26_LSB+B26_W-1]}},    instr[B26_LSB  +: B26_W]};
  assign cb19_ext = {{(OUT_W-CB19_W){instr[CB19_LSB+CB19_W-1]}}, instr[CB19_LSB +: CB19_W]};
  assign d9_ext   = {{(OUT_W-D9_W){instr[D9_LSB+D9_W-1]}},       instr[D9_LSB   +: D9_W]};
  assign i12_ext  = {{(OUT_W-I12_W){1'b0}},                      instr[I12_LSB  +: I12_W]};

  // hw field selects a 16-bit lane: shift by 16*hw
  assign mw_shift = {instr[MW_HW_LSB +: 2], 4'b0000};
  assign mw16_ext = {{(OUT_W-MW16_W){1'b0}}, instr[MW16_LSB +: MW16_W]} << mw_shift;

`ifdef BRANCH_SHL2_EN
  assign b26_off  = b26_ext << 2;
  assign cb19_off = cb19_ext << 2;
`else
  assign b26_off  = b26_ext;
  assign cb19_off = cb19_ext;
`endif

  // Pick the extended field matching the decoded class
  always_comb begin
    imm = '0;
    case (kind)
      KIND_B26:  imm = b26_off;
      KIND_CB19: imm = cb19_off;
      KIND_D9:   imm = d9_ext;
      KIND_I12:  imm = i12_ext;
      KIND_MW16: imm = mw16_ext;
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_ctrl.sv
// LEGv8 immediate generator: decodes each accepted instruction word and
// buffers {imm, imm_kind} in a 2-entry FIFO with valid/ready on both sides.
// Optional macro BRANCH_SHL2_EN (see imm_field_ext) selects byte-offset
// branch immediates.
module imm_gen_ctrl
  import imm_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input logic          clk,
  input logic          reset,
  imm_gen_ctrl_if.slave bus
);

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    imm_kind_t        kind;
  } entry_t;

  logic [OUT_W-1:0] dec_imm;
  imm_kind_t        dec_kind;
  entry_t           dec;
  entry_t           slot0;   // head of the FIFO, drives the outputs
  entry_t           slot1;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  imm_field_ext #(.OUT_W(OUT_W)) u_field_ext (
    .instr (bus.instr),
    .imm   (dec_imm),
    .kind  (dec_kind)
  );

  assign dec = '{imm: dec_imm, kind: dec_kind};

  // Ready depends only on stored occupancy, so a pop never frees a slot
  // for the same cycle and there is no path from out_ready to in_ready
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.imm       = slot0.imm;
  assign bus.imm_kind  = slot0.kind;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // FIFO storage and occupancy; reset and flush both empty it and clear the head
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // only reachable with one entry stored: replace the head in place
          slot0 <= dec;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= dec;
          else               slot1 <= dec;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_ctrl.sv
// Self-checking bench for imm_gen_ctrl: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_imm_gen_ctrl;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imm_gen_ctrl_if #(.OUT_W(64)) bus();

  imm_gen_ctrl #(.OUT_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] imm;
    int          kind;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  exp_t q[$];

`ifdef BRANCH_SHL2_EN
  localparam logic [63:0] E_B    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] E_BL   = 64'd4;
  localparam logic [63:0] E_CBZ  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] E_BC   = 64'd64;
  localparam logic [63:0] E_CBNZ = 64'd4;
`else
  localparam logic [63:0] E_B    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] E_BL   = 64'd1;
  localparam logic [63:0] E_CBZ  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] E_BC   = 64'd16;
  localparam logic [63:0] E_CBNZ = 64'd1;
`endif

  localparam int NV = 12;
  localparam logic [31:0] VEC_INSTR [NV] = '{
    32'h17FF_FFFF,  // B     imm26=3FFFFFF
    32'h9400_0001,  // BL    imm26=1
    32'hB4FF_FFE0,  // CBZ   imm19=7FFFF
    32'h5400_0201,  // B.cond imm19=16
    32'hB500_0020,  // CBNZ  imm19=1
    32'h913F_FC00,  // ADDI  imm12=FFF
    32'hD104_8C00,  // SUBI  imm12=123
    32'hF850_0000,  // LDUR  imm9=100
    32'hF800_5000,  // STUR  imm9=5
    32'hD2C2_4680,  // MOVZ  hw=2 imm16=1234
    32'hD2FF_FFE0,  // MOVZ  hw=3 imm16=FFFF
    32'h8B02_0020   // ADD register
  };
  localparam logic [63:0] VEC_IMM [NV] = '{
    E_B, E_BL, E_CBZ, E_BC, E_CBNZ,
    64'h0000_0000_0000_0FFF, 64'h0000_0000_0000_0123,
    64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_0000_0005,
    64'h0000_1234_0000_0000, 64'hFFFF_0000_0000_0000,
    64'h0
  };
  localparam int VEC_KIND [NV] = '{1, 1, 2, 2, 2, 4, 4, 3, 3, 5, 5, 0};

  // Reference: immediate value from the instruction-set rules as plain arithmetic
  function automatic exp_t model(input logic [31:0] w);
    exp_t   e;
    longint v;
    e.imm  = 64'h0;
    e.kind = 0;
    v      = 0;
    if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
      v = longint'(w[25:0]);
      if (w[25]) v = v - (longint'(1) << 26);
`ifdef BRANCH_SHL2_EN
      v = v * 4;
`endif
      e.imm  = v;
      e.kind = 1;
    end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5 || w[31:24] == 8'h54) begin
      v = longint'(w[23:5]);
      if (w[23]) v = v - (longint'(1) << 19);
`ifdef BRANCH_SHL2_EN
      v = v * 4;
`endif
      e.imm  = v;
      e.kind = 2;
    end else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
      v = longint'(w[20:12]);
      if (w[20]) v = v - (longint'(1) << 9);
      e.imm  = v;
      e.kind = 3;
    end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
      e.imm  = 64'(w[21:10]);
      e.kind = 4;
    end else if (w[31:23] == 9'b110100101) begin
      e.imm  = 64'(w[20:5]) * (64'd1 << (int'(w[22:21]) * 16));
      e.kind = 5;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model update on each active edge from the inputs presented that cycle
  always @(posedge clk) begin
    if (reset || bus.flush) begin
      q.delete();
    end else if (bus.in_valid && q.size() < 2) begin
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      q.push_back(model(bus.instr));
    end else if (q.size() != 0 && bus.out_ready) begin
      void'(q.pop_front());
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      if (q.size() != 0 && bus.out_valid) begin
        chk("head_imm", bus.imm, q[0].imm);
        chk("head_kind", 64'(bus.imm_kind), 64'(q[0].kind));
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    step();
    step();
    reset   = 1'b0;
    started = 1'b1;

    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_imm", bus.imm, 64'd0);
    chk("rst_kind", 64'(bus.imm_kind), 64'(KIND_NONE));

    // Directed decode vectors, one per cycle, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.instr    = VEC_INSTR[i];
      step();
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_imm", i), bus.imm, VEC_IMM[i]);
      chk($sformatf("vec%0d_kind", i), 64'(bus.imm_kind), 64'(VEC_KIND[i]));
      chk($sformatf("model%0d_imm", i), model(VEC_INSTR[i]).imm, VEC_IMM[i]);
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: three pushes with the consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h9100_0400;   // ADDI #1
    step();
    bus.instr     = 32'h9100_0800;   // ADDI #2
    step();
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    bus.instr     = 32'h9100_0C00;   // ADDI #3
    step();
    chk("bp_still_full", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_imm", bus.imm, 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("bp_head_b", bus.imm, 64'd2);
    chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_head_c", bus.imm, 64'd3);
    step();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush while full with a simultaneous push and pop
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h9100_0400;
    step();
    bus.instr     = 32'h9100_0800;
    step();
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.instr     = 32'h9100_0C00;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    step();
    chk("flush_nothing_out", 64'(bus.out_valid), 64'd0);

    // Reset with one entry buffered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'hD2C2_4680;
    step();
    bus.in_valid  = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_imm", bus.imm, 64'd0);
    chk("mid_rst_kind", 64'(bus.imm_kind), 64'(KIND_NONE));
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    step();

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
